// File: rtl/dds_pkg.sv
// dds_pkg: shared widths and sweep state encoding for the DDS sweep controller
package dds_pkg;
  localparam int PHASE_W_DEF = 32;
  localparam int DWELL_W_DEF = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_PAUSE, ST_DONE} state_e;
endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: per-frequency dwell counter; a zero load value counts as one cycle
module dds_dwell_timer import dds_pkg::*; #(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               hold_i,
  input  logic [DWELL_W-1:0] load_val_i,
  output logic               expire_o
);
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr_i ? '0 :
            load_i ? ((load_val_i == '0) ? DWELL_W'(1) : load_val_i) :
            (hold_i || cnt_q == '0) ? cnt_q : cnt_q - DWELL_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expire_o = (cnt_q == DWELL_W'(1));
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: stepped frequency sweep sequencer driving an external DDS core
module dds_sweep_ctrl import dds_pkg::*; #(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               pause_i,
  input  logic               continuous_i,
  input  logic [PHASE_W-1:0] start_word_i,
  input  logic [PHASE_W-1:0] stop_word_i,
  input  logic [PHASE_W-1:0] step_word_i,
  input  logic [DWELL_W-1:0] dwell_cycles_i,
  input  logic [PHASE_W-1:0] phase_cfg_i,
  output logic [PHASE_W-1:0] freq_word_o,
  output logic [PHASE_W-1:0] phase_shift_o,
  output logic               clk_en_o,
  output logic               busy_o,
  output logic               done_o
);
  state_e state_q, state_d;
  logic [PHASE_W-1:0] freq_q, freq_d, phase_q, phase_d, start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic cont_q, cont_d, down_q, down_d;
  logic [PHASE_W:0] sum, diff;
  logic [PHASE_W-1:0] next_freq;
  logic last_pt, expire, ld, clr;
  assign sum  = {1'b0, freq_q} + {1'b0, step_q};
  assign diff = {1'b0, freq_q} - {1'b0, step_q};
  // the extra MSB catches wrap past either end of the word range
  assign next_freq = down_q ? ((diff[PHASE_W] || diff[PHASE_W-1:0] < stop_q) ? stop_q : diff[PHASE_W-1:0])
                            : ((sum[PHASE_W] || sum[PHASE_W-1:0] > stop_q) ? stop_q : sum[PHASE_W-1:0]);
  assign last_pt = (freq_q == stop_q) || (step_q == '0);
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    phase_d = phase_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    down_d  = down_q;
    ld      = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i && !abort_i) begin
        state_d = ST_SWEEP;
        freq_d  = start_word_i;
        phase_d = phase_cfg_i;
        start_d = start_word_i;
        stop_d  = stop_word_i;
        step_d  = step_word_i;
        dwell_d = dwell_cycles_i;
        cont_d  = continuous_i;
        down_d  = start_word_i > stop_word_i;
        ld      = 1'b1;
      end
      ST_SWEEP: if (pause_i) state_d = ST_PAUSE;
        else if (expire) begin
          ld      = !last_pt || cont_q;
          freq_d  = !last_pt ? next_freq : (cont_q ? start_q : freq_q);
          state_d = (last_pt && !cont_q) ? ST_DONE : ST_SWEEP;
        end
      ST_PAUSE: state_d = pause_i ? ST_PAUSE : ST_SWEEP;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      freq_d  = '0;
      clr     = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      freq_q  <= '0;
      phase_q <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      phase_q <= phase_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      down_q  <= down_d;
    end
  end
  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .load_i     (ld),
    .hold_i     (state_q != ST_SWEEP || pause_i),
    .load_val_i ((state_q == ST_IDLE) ? dwell_cycles_i : dwell_q),
    .expire_o   (expire)
  );
  assign freq_word_o   = freq_q;
  assign phase_shift_o = phase_q;
  assign clk_en_o      = (state_q == ST_SWEEP) || (state_q == ST_PAUSE);
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter PHASE_W, default 32, width of every frequency and phase word.
REQ-002 Parameter DWELL_W, default 16, width of the dwell counter and DwellCycles.
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  sweep request, sampled only in IDLE.
REQ-006 Abort  input  1  terminate any activity; wins over all other inputs except reset.
REQ-007 Pause  input  1  freeze sweep while high (SWEEP/PAUSE only).
REQ-008 Continuous  input  1  0 = single sweep, 1 = repeat until Abort.
REQ-009 StartWord  input  PHASE_W  first frequency word.
REQ-010 StopWord  input  PHASE_W  last frequency word.
REQ-011 StepWord  input  PHASE_W  unsigned step magnitude.
REQ-012 DwellCycles  input  DWELL_W  clocks spent at each frequency.
REQ-013 PhaseCfg  input  PHASE_W  phase offset for the DDS.
REQ-014 FreqWord  output  PHASE_W  registered frequency word to the DDS.
REQ-015 PhaseShift  output  PHASE_W  registered phase offset to the DDS.
REQ-016 ClkEn  output  1  registered DDS enable; 0 resets DDS phase accumulator.
REQ-017 Busy  output  1  high in every state except IDLE.
REQ-018 Done  output  1  one-cycle pulse at end of a single sweep.

Function
REQ-019 States SHALL be IDLE, SWEEP, PAUSE, DONE.
REQ-020 IDLE with Start=1 SHALL latch StartWord, StopWord, StepWord, DwellCycles, PhaseCfg, Continuous and direction (down if StartWord>StopWord), entering SWEEP next cycle with FreqWord=StartWord, PhaseShift=PhaseCfg, ClkEn=1.
REQ-021 Config inputs SHALL be ignored after latching; Start SHALL be ignored outside IDLE.
REQ-022 Each frequency SHALL be held exactly max(DwellCycles,1) cycles (DwellCycles=0 treated as 1).
REQ-023 At dwell expiry with FreqWord≠StopWord, FreqWord SHALL move one StepWord toward StopWord, clamped to StopWord on overshoot or arithmetic wrap.
REQ-024 At dwell expiry with FreqWord=StopWord: single mode -> DONE; continuous -> FreqWord=StartWord, stay in SWEEP, no Done.
REQ-025 StepWord=0 SHALL be treated as a one-point sweep: StartWord held one dwell, then as REQ-024 (FreqWord set to StopWord not required).
REQ-026 DONE SHALL last one cycle with Done=1, ClkEn=0, then IDLE; FreqWord retains last value.
REQ-027 SWEEP with Pause=1 SHALL enter PAUSE next cycle; PAUSE freezes dwell counter and FreqWord, ClkEn stays 1; Pause=0 returns to SWEEP resuming the remaining count.
REQ-028 Abort=1 in any non-IDLE state SHALL give IDLE next cycle, ClkEn=0, Done=0, FreqWord=0.
REQ-029 Start and Abort both high in IDLE SHALL remain IDLE.
REQ-030 Outputs SHALL be registered; no combinational path input->output.

Reset
REQ-031 Rst_n low SHALL immediately force IDLE, FreqWord=0, PhaseShift=0, ClkEn=0, Busy=0, Done=0, dwell counter=0, regardless of state.
REQ-032 First Start SHALL be accepted on the first edge after Rst_n deasserts.

Structure
REQ-033 Package dds_pkg SHALL hold PHASE_W/DWELL_W defaults and the state encoding.
REQ-034 One sub-module dds_dwell_timer (load, hold, expire flag) SHALL implement the dwell counter; the DDS core is instantiated outside this block.

Verification
REQ-035 Start=100, Stop=130, Step=10, Dwell=3, single, Start at edge 0 -> FreqWord 100 cycles 1-3, 110 4-6, 120 7-9, 130 10-12, Done=1 cycle 13, Busy=0 cycle 14.
REQ-036 Start=0, Stop=25, Step=10, Dwell=1 -> FreqWord 0,10,20,25 then Done; Start=50, Stop=20, Step=15 -> 50,35,20.
REQ-037 Continuous, Start=5, Stop=7, Step=1, Dwell=2 -> 5,5,6,6,7,7,5,5,... no Done; Abort -> IDLE, ClkEn=0 next cycle.
REQ-038 Pause held 4 cycles mid-dwell of 110 in REQ-035 -> 110 lasts 3+4+1 transition cycles, later timing shifted by 5.
REQ-039 Rst_n low mid-sweep -> all outputs 0 asynchronously; Start after release restarts from StartWord.
REQ-040 Start while Busy, StepWord=0, DwellCycles=0, Start+Abort together -> behaviour per REQ-021/025/022/029.
